// File: rtl/ft2232h_pkg.sv
// Shared types and constants for the FT2232H sync-FIFO controllers.
// Holds level constants, byte type, counter width and TX state enum.
package ft2232h_pkg;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  localparam int COUNT_W = 32;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with MSB-extended pointers.
// Ports: clk, rst_n, push/push_data, pop/pop_data, full, empty, level.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [ADDR_W:0]  level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wptr;
  logic [ADDR_W:0]  rptr;
  logic             do_push;
  logic             do_pop;

  assign full =
    (wptr[ADDR_W] != rptr[ADDR_W]) &&
    (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty = (wptr == rptr);
  assign level = wptr - rptr;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign pop_data = mem[rptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[ADDR_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + (ADDR_W+1)'(1);
      end
      if (do_pop) begin
        rptr <= rptr + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ft2232h_tx_ctrl.sv
// FT2232H sync-FIFO write controller: buffer, output register, counter.
// Ports: clkout_i, rst_n_i, din_*, txe_i, data_o, wr_n_o, level_o, tx_count_o.
module ft2232h_tx_ctrl
  import ft2232h_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clkout_i,
  input  logic               rst_n_i,
  input  logic [7:0]         din_i,
  input  logic               din_valid_i,
  output logic               din_ready_o,
  input  logic               txe_i,
  output logic [7:0]         data_o,
  output logic               wr_n_o,
  output logic [ADDR_W:0]    level_o,
  output logic [COUNT_W-1:0] tx_count_o
);

  tx_state_t          state_q;
  tx_state_t          state_d;
  logic               wr_n_q;
  byte_t              data_q;
  logic [COUNT_W-1:0] tx_count_q;

  logic  full;
  logic  empty;
  byte_t head;
  logic  push;
  logic  load;
  logic  accepted;

  // Ready comes only from the registered full flag.
  assign din_ready_o = ~full;
  assign push        = din_valid_i & ~full;
  assign accepted    = (wr_n_q == LO) && (txe_i == LO);

  sync_fifo #(
    .WIDTH  (8),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clkout_i),
    .rst_n     (rst_n_i),
    .push      (push),
    .push_data (din_i),
    .pop       (load),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level_o)
  );

  always_comb begin
    state_d = state_q;
    load    = LO;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (!empty) begin
          load    = HI;
          state_d = ST_SEND;
        end
      end
      (state_q == ST_SEND): begin
        if (accepted) begin
          if (!empty) begin
            load = HI;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkout_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      wr_n_q  <= HI;
    end else begin
      state_q <= state_d;
      wr_n_q  <= (state_d != ST_SEND);
    end
  end

  // Held byte keeps its value once the buffer runs dry.
  always_ff @(posedge clkout_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= 8'h00;
    end else if (load) begin
      data_q <= head;
    end
  end

  always_ff @(posedge clkout_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_count_q <= '0;
    end else if (accepted) begin
      tx_count_q <= tx_count_q + COUNT_W'(1);
    end
  end

  assign data_o     = data_q;
  assign wr_n_o     = wr_n_q;
  assign tx_count_o = tx_count_q;

endmodule

// File: tb/tb_ft2232h_tx_ctrl.sv
// Scoreboard bench for ft2232h_tx_ctrl with an FT2232H receiver model.
// Directed phases plus a randomized burst/backpressure phase.
module tb_ft2232h_tx_ctrl;
  import ft2232h_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  byte_t       din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        txe = 1'b1;
  byte_t       data;
  logic        wr_n;
  logic [AW:0] level;
  logic [31:0] tx_count;

  always #5 clk = ~clk;

  ft2232h_tx_ctrl #(.DEPTH(DEPTH)) dut (
    .clkout_i    (clk),
    .rst_n_i     (rst_n),
    .din_i       (din),
    .din_valid_i (din_valid),
    .din_ready_o (din_ready),
    .txe_i       (txe),
    .data_o      (data),
    .wr_n_o      (wr_n),
    .level_o     (level),
    .tx_count_o  (tx_count)
  );

  int          checks = 0;
  int          errors = 0;
  byte_t       expq[$];
  byte_t       acc_log[$];
  int          acc_cyc[$];
  logic [31:0] acc_cnt = '0;
  bit          cnt_chk_en = 1'b1;
  int          cyc = 0;
  bit          rand_on;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PC-side model: a byte lands on each edge with WR# and TXE# low.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (cnt_chk_en) chk("tx_count", tx_count, acc_cnt);
      if (!wr_n && !txe) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none",
                   data);
        end else begin
          chk("byte", {24'h0, data}, {24'h0, expq.pop_front()});
        end
        acc_cnt++;
        acc_cyc.push_back(cyc);
        acc_log.push_back(data);
      end
    end
  end

  task automatic send(byte_t b);
    bit done;
    done = 1'b0;
    din = b;
    din_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (din_ready) begin
        expq.push_back(b);
        done = 1'b1;
      end
      tick();
    end
    din_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stuck required=%0h", b);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      tick();
      if (expq.size() == 0 && wr_n) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0",
               expq.size());
    end
  endtask

  function automatic int count_of(byte_t b);
    int n;
    n = 0;
    foreach (acc_log[i]) if (acc_log[i] == b) n++;
    return n;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit found;

    repeat (3) @(negedge clk);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_data", data, 0);
    chk("rst_ready", din_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_count", tx_count, 0);
    tick();
    rst_n = 1'b1;

    // Single byte latency
    txe = 1'b0;
    din = 8'hA5;
    din_valid = 1'b1;
    @(negedge clk);
    chk("single_ready", din_ready, 1);
    expq.push_back(8'hA5);
    tick();
    din_valid = 1'b0;
    @(negedge clk);
    chk("single_n1_wr_n", wr_n, 1);
    chk("single_n1_level", level, 1);
    tick();
    @(negedge clk);
    chk("single_n2_wr_n", wr_n, 0);
    chk("single_n2_data", data, 8'hA5);
    chk("single_n2_level", level, 0);
    tick();
    @(negedge clk);
    chk("single_done_wr_n", wr_n, 1);
    chk("single_done_count", tx_count, 1);
    chk("single_hold_data", data, 8'hA5);
    chk("single_q_empty", expq.size(), 0);
    tick();

    // Back-to-back burst
    acc_cyc.delete();
    for (int i = 0; i < 16; i++) send(byte_t'(i));
    drain();
    chk("burst_n", acc_cyc.size(), 16);
    if (acc_cyc.size() == 16)
      chk("burst_gapless", acc_cyc[15] - acc_cyc[0], 15);
    chk("burst_count", tx_count, 17);

    // Backpressure fill
    txe = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) send(byte_t'(8'h40 + i));
      end
    join_none
    repeat (25) tick();
    @(negedge clk);
    chk("bp_ready", din_ready, 0);
    chk("bp_level", level, 16);
    chk("bp_wr_n", wr_n, 0);
    chk("bp_data", data, 8'h40);
    tick();
    txe = 1'b0;
    wait fork;
    drain();
    chk("bp_count", tx_count, 37);

    // TXE# pulse on byte 37
    acc_log.delete();
    found = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(byte_t'(8'h30 + i));
      end
    join_none
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk);
      #1;
      if (!wr_n && data == 8'h37) found = 1'b1;
    end
    chk("tog_found", found, 1);
    txe = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("tog_hold_data", data, 8'h37);
      chk("tog_hold_wr_n", wr_n, 0);
      tick();
    end
    txe = 1'b0;
    wait fork;
    drain();
    chk("tog_once", count_of(8'h37), 1);

    // Reset with five bytes buffered
    txe = 1'b1;
    for (int i = 0; i < 6; i++) send(byte_t'(8'h60 + i));
    tick();
    @(negedge clk);
    chk("mid_level", level, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_n", wr_n, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ready", din_ready, 1);
    expq.delete();
    acc_cnt = '0;
    txe = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_no_stale", wr_n, 1);
    chk("mid_count", tx_count, 0);
    send(8'h5A);
    drain();
    chk("mid_after_count", tx_count, 1);

    // Randomized traffic
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(byte_t'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 2)) tick();
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          tick();
          txe = ($urandom_range(0, 3) == 0);
        end
      end
    join
    txe = 1'b0;
    drain();
    chk("rand_count", tx_count, 201);

    // Counter wrap
    @(negedge clk);
    cnt_chk_en = 1'b0;
    force dut.tx_count_q = 32'hFFFF_FFFF;
    tick();
    @(negedge clk);
    release dut.tx_count_q;
    acc_cnt = 32'hFFFF_FFFF;
    cnt_chk_en = 1'b1;
    tick();
    chk("wrap_pre", tx_count, 32'hFFFF_FFFF);
    send(8'hC3);
    drain();
    chk("wrap", tx_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
